// File: rtl/seq_divider_pkg.sv
// Shared encodings and constants for the restoring shift-subtract divider.
package seq_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_CALC  = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v,
                                                  input logic sgn);
    return (sgn && v[DIV_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift {rem, quo} left, subtract divisor if it fits.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH:0]   rem_o,
  output logic [DIV_WIDTH-1:0] quo_o
);
  logic [DIV_WIDTH+1:0] trial;

  // rem < divisor before the shift, so the shifted value never sets the top bit;
  // trial's top bit is therefore a clean borrow flag.
  assign trial = {rem_i, quo_i[DIV_WIDTH-1]} - {2'b00, divisor_i};
  assign rem_o = trial[DIV_WIDTH+1] ? {rem_i[DIV_WIDTH-1:0], quo_i[DIV_WIDTH-1]}
                                    : trial[DIV_WIDTH:0];
  assign quo_o = {quo_i[DIV_WIDTH-2:0], ~trial[DIV_WIDTH+1]};
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle 32-bit DIV/DIVU: capture magnitudes, 32 restoring steps, sign fixup.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);
  div_state_e           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [DIV_WIDTH:0]   rem_q, rem_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DIV_WIDTH-1:0] quotient_q, quotient_d;
  logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;
  logic [DIV_WIDTH:0]   step_rem;
  logic [DIV_WIDTH-1:0] step_quo;
  logic                 accept;

  div_step u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  assign accept = Start && (state_q == DIV_IDLE || state_q == DIV_DONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (accept) begin
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = div_abs(Dividend, Signed);
      dvs_d  = div_abs(Divisor, Signed);
      qneg_d = Signed && (Dividend[DIV_WIDTH-1] ^ Divisor[DIV_WIDTH-1]);
      rneg_d = Signed && Dividend[DIV_WIDTH-1];
      dbz_d  = (Divisor == '0);
      if (Divisor == '0) begin
        // Divide by zero skips the datapath and reports the raw dividend.
        state_d     = DIV_DONE;
        quotient_d  = DIV_DBZ_QUO;
        remainder_d = Dividend;
      end else begin
        state_d = DIV_CALC;
      end
    end else begin
      case (state_q)
        DIV_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) state_d = DIV_FIXUP;
        end
        DIV_FIXUP: begin
          quotient_d  = qneg_q ? -quo_q : quo_q;
          remainder_d = rneg_q ? -rem_q[DIV_WIDTH-1:0] : rem_q[DIV_WIDTH-1:0];
          state_d     = DIV_DONE;
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign Busy      = (state_q == DIV_CALC) || (state_q == DIV_FIXUP);
  assign Done      = (state_q == DIV_DONE);
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign DivByZero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: latency, signed/unsigned results, DBZ, handshake, reset.
module tb_seq_divider;
  logic        Clk = 1'b0;
  logic        Reset, Start, Signed;
  logic [31:0] Dividend, Divisor;
  logic        Busy, Done, DivByZero;
  logic [31:0] Quotient, Remainder;

  int n_chk  = 0;
  int n_pass = 0;

  seq_divider #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Signed   (Signed),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Drive a request at the negedge; returns #1 after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge Clk);
    Dividend = a; Divisor = b; Signed = s; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Counts edges until Done, flagging any cycle where neither Busy nor Done is high.
  task automatic wait_done(output int n, output int busy_gaps);
    n = 0; busy_gaps = 0;
    while (!Done && n < 100) begin
      if (!Busy) busy_gaps++;
      @(posedge Clk);
      #1 n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    int n, gaps;
    launch(a, b, s);
    wait_done(n, gaps);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_busy"}, gaps, 0);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dbz"}, {31'd0, DivByZero}, 0);
  endtask

  initial begin
    int n, gaps, dones;
    Reset = 1'b1; Start = 1'b0; Signed = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_dbz", {31'd0, DivByZero}, 0);
    @(negedge Clk) Reset = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    @(posedge Clk); #1;
    chk("done_pulse", {31'd0, Done}, 0);
    chk("hold_q", Quotient, 32'd14);

    run_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("u_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);

    // Divide by zero completes one cycle after acceptance without Busy.
    launch(32'd5, 32'd0, 1'b0);
    chk("dbz_done", {31'd0, Done}, 1);
    chk("dbz_flag", {31'd0, DivByZero}, 1);
    chk("dbz_busy", {31'd0, Busy}, 0);
    chk("dbz_q", Quotient, 32'hFFFF_FFFF);
    chk("dbz_r", Remainder, 32'd5);

    // Start in the Done cycle is accepted and clears DivByZero.
    launch(32'd100, 32'd7, 1'b0);
    chk("dbz_clear", {31'd0, DivByZero}, 0);
    chk("b2b_busy", {31'd0, Busy}, 1);
    wait_done(n, gaps);
    chk("ign_base_lat", n, 33);

    // Start at edge 10 of a busy op is ignored.
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Dividend = 32'd9; Divisor = 32'd4; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done(n, gaps);
    chk("ign_lat", n, 23);
    chk("ign_q", Quotient, 32'd14);
    chk("ign_r", Remainder, 32'd2);

    // Back-to-back: next Done 34 edges after the previous one.
    launch(32'd9, 32'd4, 1'b0);
    wait_done(n, gaps);
    chk("b2b_lat", n, 33);
    chk("b2b_q", Quotient, 32'd2);
    chk("b2b_r", Remainder, 32'd1);

    // Reset at edge 15 of 100/7, with a simultaneous Start that must be ignored.
    launch(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; Dividend = 32'd9; Divisor = 32'd4;
    @(posedge Clk);
    #1 Reset = 1'b0; Start = 1'b0;
    chk("mrst_busy", {31'd0, Busy}, 0);
    chk("mrst_done", {31'd0, Done}, 0);
    chk("mrst_q", Quotient, 0);
    chk("mrst_r", Remainder, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done || Busy) dones++;
    end
    chk("mrst_quiet", dones, 0);
    run_op("post_rst", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
